ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Port: clk  in  1  single clock, rising-edge.
REQ-002 Port: reset  in  1  asynchronous, active-high.
REQ-003 Ports (from ID/EX): valid_in 1, pc_in 32, rs1_val_in 32, rs2_val_in 32, imm_in 32, alu_ctrl_in 4, reg_write_in 1, mem_read_in 1, mem_write_in 1, use_imm_in 1, branch_in 1, jal_in 1, rd_idx_in 5; all in.
REQ-004 Port: stall_in  in  1  MEM stage cannot accept; EX/MEM outputs SHALL hold.
REQ-005 Port: busy_out  out  1  combinational; upstream SHALL hold ID/EX while high.
REQ-006 Ports (EX/MEM, registered): valid_out 1, alu_result_out 32, store_data_out 32, rd_idx_out 5, reg_write_out 1, mem_read_out 1, mem_write_out 1; all out.
REQ-007 Ports: redirect_valid_out  out  1  registered one-cycle pulse; redirect_target_out  out  32  registered PC target.

Function
REQ-008 Operand A = rs1_val_in; operand B = use_imm_in ? imm_in : rs2_val_in.
REQ-009 alu_ctrl encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL (low 32 bits); 11-15 result 0.
REQ-010 Shift amount = B[4:0]; all arithmetic modulo 2^32, no overflow flag.
REQ-011 accept = valid_in & !stall_in & state==IDLE & alu_ctrl_in!=MUL; on accept, EX/MEM captures result, rs2_val_in as store_data, rd/control fields, valid_out=1 (latency 1 edge).
REQ-012 jal_in=1: alu_result_out = pc_in+4; redirect taken.
REQ-013 branch_in=1 taken iff (SUB and A==B) or (SLT/SLTU and result==1); other ctrl values not taken.
REQ-014 Taken branch/jal on accept: next edge redirect_valid_out=1, redirect_target_out=pc_in+imm_in; redirect_valid_out SHALL clear on the following edge regardless of stall_in.
REQ-015 valid_in=0, !stall_in, IDLE: bubble written: valid_out, reg_write_out, mem_read_out, mem_write_out = 0.
REQ-016 stall_in=1: all EX/MEM outputs hold; no accept; no MUL start.
REQ-017 FSM states IDLE, MUL_RUN, MUL_DONE.
REQ-018 IDLE -> MUL_RUN when valid_in & !stall_in & alu_ctrl_in==MUL; latch A, B, rd/control; counter=0; EX/MEM gets bubble.
REQ-019 MUL_RUN: one shift-add step per edge; after 32 steps (counter 31) -> MUL_DONE.
REQ-020 MUL_DONE & !stall_in: write product, valid_out=1, -> IDLE; MUL_DONE & stall_in: wait.
REQ-021 MUL result valid_out SHALL rise on the 34th edge after start edge with no stalls.
REQ-022 busy_out = stall_in | state!=IDLE | (valid_in & alu_ctrl_in==MUL).
REQ-023 MUL never branches/redirects; branch_in/jal_in with MUL ctrl ignored.

Reset
REQ-024 reset asserted: state=IDLE, counter=0, every registered output 0, regardless of MUL in progress.
REQ-025 busy_out during reset follows REQ-022 with state=IDLE.
REQ-026 First accept possible on first rising edge after reset deasserts.

Structure
REQ-027 Package ex_pkg: alu_op_e enum (REQ-009 codes), ex_state_e enum, MUL_STEPS=32 constant.
REQ-028 One sub-module seq_multiplier (start, operands, done, product low 32); ALU, branch logic, EX/MEM register stay in ex_stage.

Verification
REQ-029 ADD A=5, imm=7, use_imm=1, rd=3 -> next edge valid_out=1, alu_result_out=12, rd_idx_out=3.
REQ-030 SUB branch A=B=0x10, pc=0x100, imm=0x20 -> redirect_valid_out=1 one cycle, target=0x120; A=0x10,B=0x11 -> no redirect.
REQ-031 JAL pc=0x40, imm=-8 -> alu_result_out=0x44, target=0x38.
REQ-032 MUL 0xFFFFFFFF x 3 -> busy_out high 34 cycles, alu_result_out=0xFFFFFFFD on 34th edge.
REQ-033 stall_in=1 during MUL_DONE for 5 cycles -> outputs hold, result written on first edge with stall_in=0.
REQ-034 reset pulse at MUL step 10 -> all outputs 0, state IDLE; subsequent ADD completes normally.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage and its sequential multiplier.
package ex_pkg;

    // ALU operation codes as carried on alu_ctrl_in; codes 11-15 are unused and yield 0
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_e;

    // Execute-stage control: single-cycle ops run in IDLE, MUL walks RUN then DONE
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_RUN  = 2'd1,
        ST_MUL_DONE = 2'd2
    } ex_state_e;

    // One shift-add step per multiplier bit
    localparam int MUL_STEPS = 32;

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier producing the low 32 bits of a*b over MUL_STEPS edges.
module seq_multiplier
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] product
);

    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [4:0]  count;
    logic        running;

    // done flags the edge that performs the final step, so product is complete right after it
    assign done    = running && (count == 5'(MUL_STEPS - 1));
    assign product = acc;

    // Latch operands on start, then add the shifted multiplicand for each set multiplier bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            mcand   <= a;
            mplier  <= b;
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, branch/jump resolution, multi-cycle MUL and the EX/MEM register.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] rs1_val_in,
    input  logic [31:0] rs2_val_in,
    input  logic [31:0] imm_in,
    input  logic [3:0]  alu_ctrl_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        use_imm_in,
    input  logic        branch_in,
    input  logic        jal_in,
    input  logic [4:0]  rd_idx_in,
    input  logic        stall_in,
    output logic        busy_out,
    output logic        valid_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [4:0]  rd_idx_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        redirect_valid_out,
    output logic [31:0] redirect_target_out
);

    ex_state_e   state;
    ex_state_e   next_state;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_result;
    logic [31:0] ex_result;
    logic        branch_cond;
    logic        taken;
    logic        is_mul;
    logic        accept;
    logic        mul_start;
    logic        mul_done;
    logic [31:0] mul_product;
    logic [4:0]  mul_rd_idx;
    logic [31:0] mul_store_data;
    logic        mul_reg_write;
    logic        mul_mem_read;
    logic        mul_mem_write;

    assign op_a      = rs1_val_in;
    assign op_b      = use_imm_in ? imm_in : rs2_val_in;
    assign shamt     = op_b[4:0];
    assign is_mul    = (alu_ctrl_in == ALU_MUL);
    assign accept    = valid_in && !stall_in && (state == ST_IDLE) && !is_mul;
    assign mul_start = valid_in && !stall_in && (state == ST_IDLE) && is_mul;
    assign taken     = jal_in || (branch_in && branch_cond);
    assign ex_result = jal_in ? (pc_in + 32'd4) : alu_result;
    assign busy_out  = stall_in || (state != ST_IDLE) || (valid_in && is_mul);

    // Single-cycle ALU; MUL and the unused codes produce 0 here
    always_comb begin
        alu_result = '0;
        case (alu_ctrl_in)
            ALU_ADD:  alu_result = op_a + op_b;
            ALU_SUB:  alu_result = op_a - op_b;
            ALU_AND:  alu_result = op_a & op_b;
            ALU_OR:   alu_result = op_a | op_b;
            ALU_XOR:  alu_result = op_a ^ op_b;
            ALU_SLL:  alu_result = op_a << shamt;
            ALU_SRL:  alu_result = op_a >> shamt;
            ALU_SRA:  alu_result = $signed(op_a) >>> shamt;
            ALU_SLT:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_result = {31'd0, op_a < op_b};
            default:  alu_result = '0;
        endcase
    end

    // Branch condition: equality via SUB, less-than via SLT/SLTU; anything else never branches
    always_comb begin
        branch_cond = 1'b0;
        case (alu_ctrl_in)
            ALU_SUB:            branch_cond = (op_a == op_b);
            ALU_SLT, ALU_SLTU:  branch_cond = (alu_result == 32'd1);
            default:            branch_cond = 1'b0;
        endcase
    end

    seq_multiplier u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: DONE waits for the MEM stage before writing the product
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (mul_start) next_state = ST_MUL_RUN;
            ST_MUL_RUN:  if (mul_done)  next_state = ST_MUL_DONE;
            ST_MUL_DONE: if (!stall_in) next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Hold the MUL destination and control fields while upstream moves on
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_rd_idx     <= '0;
            mul_store_data <= '0;
            mul_reg_write  <= 1'b0;
            mul_mem_read   <= 1'b0;
            mul_mem_write  <= 1'b0;
        end else if (mul_start) begin
            mul_rd_idx     <= rd_idx_in;
            mul_store_data <= rs2_val_in;
            mul_reg_write  <= reg_write_in;
            mul_mem_read   <= mem_read_in;
            mul_mem_write  <= mem_write_in;
        end
    end

    // EX/MEM register plus redirect pulse; the pulse is never extended by a stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out           <= 1'b0;
            alu_result_out      <= '0;
            store_data_out      <= '0;
            rd_idx_out          <= '0;
            reg_write_out       <= 1'b0;
            mem_read_out        <= 1'b0;
            mem_write_out       <= 1'b0;
            redirect_valid_out  <= 1'b0;
            redirect_target_out <= '0;
        end else begin
            redirect_valid_out <= accept && taken;
            if (accept && taken) begin
                redirect_target_out <= pc_in + imm_in;
            end
            if (!stall_in) begin
                if (accept) begin
                    valid_out      <= 1'b1;
                    alu_result_out <= ex_result;
                    store_data_out <= rs2_val_in;
                    rd_idx_out     <= rd_idx_in;
                    reg_write_out  <= reg_write_in;
                    mem_read_out   <= mem_read_in;
                    mem_write_out  <= mem_write_in;
                end else if (state == ST_MUL_DONE) begin
                    valid_out      <= 1'b1;
                    alu_result_out <= mul_product;
                    store_data_out <= mul_store_data;
                    rd_idx_out     <= mul_rd_idx;
                    reg_write_out  <= mul_reg_write;
                    mem_read_out   <= mul_mem_read;
                    mem_write_out  <= mul_mem_write;
                end else begin
                    valid_out     <= 1'b0;
                    reg_write_out <= 1'b0;
                    mem_read_out  <= 1'b0;
                    mem_write_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage with hand-computed expected values.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] pc_in;
    logic [31:0] rs1_val_in;
    logic [31:0] rs2_val_in;
    logic [31:0] imm_in;
    logic [3:0]  alu_ctrl_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        use_imm_in;
    logic        branch_in;
    logic        jal_in;
    logic [4:0]  rd_idx_in;
    logic        stall_in;
    logic        busy_out;
    logic        valid_out;
    logic [31:0] alu_result_out;
    logic [31:0] store_data_out;
    logic [4:0]  rd_idx_out;
    logic        reg_write_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic        redirect_valid_out;
    logic [31:0] redirect_target_out;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
        string       tag;
    } alu_vec_t;

    alu_vec_t vecs[11];

    ex_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .valid_in            (valid_in),
        .pc_in               (pc_in),
        .rs1_val_in          (rs1_val_in),
        .rs2_val_in          (rs2_val_in),
        .imm_in              (imm_in),
        .alu_ctrl_in         (alu_ctrl_in),
        .reg_write_in        (reg_write_in),
        .mem_read_in         (mem_read_in),
        .mem_write_in        (mem_write_in),
        .use_imm_in          (use_imm_in),
        .branch_in           (branch_in),
        .jal_in              (jal_in),
        .rd_idx_in           (rd_idx_in),
        .stall_in            (stall_in),
        .busy_out            (busy_out),
        .valid_out           (valid_out),
        .alu_result_out      (alu_result_out),
        .store_data_out      (store_data_out),
        .rd_idx_out          (rd_idx_out),
        .reg_write_out       (reg_write_out),
        .mem_read_out        (mem_read_out),
        .mem_write_out       (mem_write_out),
        .redirect_valid_out  (redirect_valid_out),
        .redirect_target_out (redirect_target_out)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] imm, input logic [3:0] op,
                                 input logic ui, input logic br, input logic jl, input logic rw,
                                 input logic mr, input logic mw, input logic [4:0] rd);
        valid_in     = v;
        pc_in        = pc;
        rs1_val_in   = a;
        rs2_val_in   = b;
        imm_in       = imm;
        alu_ctrl_in  = op;
        use_imm_in   = ui;
        branch_in    = br;
        jal_in       = jl;
        reg_write_in = rw;
        mem_read_in  = mr;
        mem_write_in = mw;
        rd_idx_in    = rd;
    endtask

    task automatic applyBubble();
        applyStimulus(1'b0, '0, '0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        int busyCycles;
        int edges;
        logic redirSeen;
        logic validSeen;

        vecs[0]  = '{4'd1,  32'd5,          32'd7,          32'hFFFF_FFFE, "sub_neg"};
        vecs[1]  = '{4'd2,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000, "and"};
        vecs[2]  = '{4'd3,  32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF, "or"};
        vecs[3]  = '{4'd4,  32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0, "xor"};
        vecs[4]  = '{4'd5,  32'd1,          32'h0000_0024,  32'h0000_0010, "sll_low5"};
        vecs[5]  = '{4'd6,  32'h8000_0000,  32'd31,         32'd1,         "srl"};
        vecs[6]  = '{4'd7,  32'h8000_0000,  32'd4,          32'hF800_0000, "sra"};
        vecs[7]  = '{4'd8,  32'hFFFF_FFFF,  32'd1,          32'd1,         "slt_signed"};
        vecs[8]  = '{4'd9,  32'hFFFF_FFFF,  32'd1,          32'd0,         "sltu"};
        vecs[9]  = '{4'd11, 32'd3,          32'd4,          32'd0,         "op11_zero"};
        vecs[10] = '{4'd0,  32'hFFFF_FFFF,  32'd2,          32'd1,         "add_wrap"};

        // Reset state, and busy_out following valid_in&MUL while reset is held
        reset    = 1'b1;
        stall_in = 1'b0;
        applyBubble();
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", 32'(valid_out), 32'd0);
        checkOutput("rst_result", alu_result_out, 32'd0);
        checkOutput("rst_redirect", 32'(redirect_valid_out), 32'd0);
        checkOutput("rst_busy_idle", 32'(busy_out), 32'd0);
        applyStimulus(1'b1, '0, 32'd2, 32'd3, '0, ALU_MUL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1);
        #1;
        checkOutput("rst_busy_mul", 32'(busy_out), 32'd1);
        applyBubble();

        // First accept on the first edge after reset release: ADD 5+7 -> x3
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, '0, 32'd5, 32'd99, 32'd7, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3);
        @(negedge clk);
        checkOutput("add_valid", 32'(valid_out), 32'd1);
        checkOutput("add_result", alu_result_out, 32'd12);
        checkOutput("add_rd", 32'(rd_idx_out), 32'd3);
        checkOutput("add_regwrite", 32'(reg_write_out), 32'd1);

        // Register-register ALU table
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, '0, vecs[i].a, vecs[i].b, 32'hDEAD_0000, vecs[i].op,
                          1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'(i + 4));
            @(negedge clk);
            checkOutput(vecs[i].tag, alu_result_out, vecs[i].expected);
        end

        // Store: address from imm, rs2 forwarded as store data
        applyStimulus(1'b1, '0, 32'h1000, 32'hDEAD_BEEF, 32'd8, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        @(negedge clk);
        checkOutput("st_addr", alu_result_out, 32'h1008);
        checkOutput("st_data", store_data_out, 32'hDEAD_BEEF);
        checkOutput("st_memwrite", 32'(mem_write_out), 32'd1);

        // Bubble
        applyBubble();
        @(negedge clk);
        checkOutput("bub_valid", 32'(valid_out), 32'd0);
        checkOutput("bub_memwrite", 32'(mem_write_out), 32'd0);

        // SUB branch, equal operands: taken, one-cycle pulse
        applyStimulus(1'b1, 32'h100, 32'h10, 32'h10, 32'h20, ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        checkOutput("beq_redir", 32'(redirect_valid_out), 32'd1);
        checkOutput("beq_target", redirect_target_out, 32'h120);
        applyBubble();
        @(negedge clk);
        checkOutput("beq_pulse_clear", 32'(redirect_valid_out), 32'd0);

        // SUB branch, unequal operands: not taken
        applyStimulus(1'b1, 32'h100, 32'h10, 32'h11, 32'h20, ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        checkOutput("bne_redir", 32'(redirect_valid_out), 32'd0);

        // SLT branch taken, then a stall: pulse still clears, EX/MEM holds
        applyStimulus(1'b1, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, ALU_SLT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        checkOutput("blt_redir", 32'(redirect_valid_out), 32'd1);
        checkOutput("blt_target", redirect_target_out, 32'h210);
        stall_in = 1'b1;
        applyStimulus(1'b1, '0, 32'd1, 32'd1, '0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9);
        @(negedge clk);
        checkOutput("stall_redir_clear", 32'(redirect_valid_out), 32'd0);
        checkOutput("stall_hold_valid", 32'(valid_out), 32'd1);
        checkOutput("stall_hold_result", alu_result_out, 32'd1);
        checkOutput("stall_hold_rd", 32'(rd_idx_out), 32'd0);
        stall_in = 1'b0;

        // JAL: link = pc+4, target = pc+imm
        applyStimulus(1'b1, 32'h40, 32'd0, 32'd0, 32'hFFFF_FFF8, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1);
        @(negedge clk);
        checkOutput("jal_link", alu_result_out, 32'h44);
        checkOutput("jal_redir", 32'(redirect_valid_out), 32'd1);
        checkOutput("jal_target", redirect_target_out, 32'h38);

        // MUL 0xFFFFFFFF x 3 with branch/jal set (ignored); count busy cycles and edges
        // from the start edge (counted as edge 1) to the result write
        applyStimulus(1'b1, 32'h80, 32'hFFFF_FFFF, 32'd3, 32'h100, ALU_MUL, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5);
        busyCycles = 0;
        edges      = 0;
        redirSeen  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (busy_out) busyCycles++;
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (redirect_valid_out) redirSeen = 1'b1;
            applyBubble();
            if (valid_out) break;
        end
        checkOutput("mul_edges", 32'(edges), 32'd34);
        checkOutput("mul_busy_cycles", 32'(busyCycles), 32'd34);
        checkOutput("mul_result", alu_result_out, 32'hFFFF_FFFD);
        checkOutput("mul_rd", 32'(rd_idx_out), 32'd5);
        checkOutput("mul_no_redirect", 32'(redirSeen), 32'd0);
        #1;
        checkOutput("mul_busy_after", 32'(busy_out), 32'd0);

        // MUL 6 x 7 with MEM stalled for 5 cycles in MUL_DONE
        @(negedge clk);
        applyStimulus(1'b1, '0, 32'd6, 32'd7, '0, ALU_MUL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7);
        @(negedge clk);
        applyBubble();
        repeat (32) @(negedge clk);
        stall_in  = 1'b1;
        validSeen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (valid_out) validSeen = 1'b1;
        end
        checkOutput("mstall_no_write", 32'(validSeen), 32'd0);
        checkOutput("mstall_hold_result", alu_result_out, 32'hFFFF_FFFD);
        checkOutput("mstall_busy", 32'(busy_out), 32'd1);
        stall_in = 1'b0;
        @(negedge clk);
        checkOutput("mstall_valid", 32'(valid_out), 32'd1);
        checkOutput("mstall_result", alu_result_out, 32'd42);
        checkOutput("mstall_rd", 32'(rd_idx_out), 32'd7);

        // Reset at MUL step 10, then a normal ADD; the aborted MUL must never write back
        applyStimulus(1'b1, '0, 32'd2, 32'd3, '0, ALU_MUL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8);
        @(negedge clk);
        applyBubble();
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(valid_out), 32'd0);
        checkOutput("arst_result", alu_result_out, 32'd0);
        checkOutput("arst_store", store_data_out, 32'd0);
        checkOutput("arst_rd", 32'(rd_idx_out), 32'd0);
        checkOutput("arst_regwrite", 32'(reg_write_out), 32'd0);
        checkOutput("arst_target", redirect_target_out, 32'd0);
        checkOutput("arst_busy", 32'(busy_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, '0, 32'd20, 32'd22, '0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2);
        @(negedge clk);
        checkOutput("post_rst_valid", 32'(valid_out), 32'd1);
        checkOutput("post_rst_result", alu_result_out, 32'd42);
        applyBubble();
        validSeen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_out) validSeen = 1'b1;
        end
        checkOutput("post_rst_no_mul", 32'(validSeen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
